// File: rtl/countdown_underflow.sv
// Loadable down-counter with sticky underflow flag and a one-cycle wrap pulse.
// All outputs are registered; priority per edge is reset > load > enable > hold.
module countdown_underflow #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             clear_flag,
    output logic [WIDTH-1:0] counter_out,
    output logic             underflow_out,
    output logic             wrap_pulse,
    output logic             zero_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] reload_q;
    logic             underflow_event;
    logic [WIDTH-1:0] wrap_value;
    logic [WIDTH-1:0] dec_value;

    // Load suppresses the underflow event even when the count is already zero.
    assign underflow_event = enable && !load && (counter_out == '0);
    assign wrap_value      = AUTO_RELOAD ? reload_q : ALL_ONES;
    assign dec_value       = underflow_event ? wrap_value : (counter_out - ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_out   <= ALL_ONES;
            reload_q      <= ALL_ONES;
            underflow_out <= 1'b0;
            wrap_pulse    <= 1'b0;
            zero_out      <= 1'b0;
        end else begin
            if (load) begin
                counter_out <= load_value;
                reload_q    <= load_value;
                zero_out    <= (load_value == '0);
            end else if (enable) begin
                counter_out <= dec_value;
                zero_out    <= (dec_value == '0);
            end

            wrap_pulse <= underflow_event;

            // A same-edge underflow wins over clear_flag.
            if (underflow_event) begin
                underflow_out <= 1'b1;
            end else if (clear_flag) begin
                underflow_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_countdown_underflow.sv
// Bench for countdown_underflow: one fixed-wrap and one auto-reload instance share
// the same directed stimulus; an arithmetic model feeds per-instance expected queues.
module tb_countdown_underflow;

    localparam int W  = 4;
    localparam int EW = W + 3;
    localparam int TOP = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         enable = 1'b0;
    logic         clear_flag = 1'b0;

    logic [W-1:0] c0, c1;
    logic         uf0, uf1, wp0, wp1, z0, z1;

    int checks = 0;
    int errors = 0;

    countdown_underflow #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_ar0 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .clear_flag(clear_flag),
        .counter_out(c0), .underflow_out(uf0), .wrap_pulse(wp0), .zero_out(z0)
    );

    countdown_underflow #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_ar1 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .clear_flag(clear_flag),
        .counter_out(c1), .underflow_out(uf1), .wrap_pulse(wp1), .zero_out(z1)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: integer count, reload memory, flag bits
    int           m_cnt [2];
    int           m_rel [2];
    bit           m_uf  [2];
    bit           m_wp  [2];
    bit           m_ev;
    logic [EW-1:0] m_e;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_ev = 1'b0;
            if (reset) begin
                m_cnt[i] = TOP;
                m_rel[i] = TOP;
                m_uf[i]  = 1'b0;
                m_wp[i]  = 1'b0;
            end else begin
                if (load) begin
                    m_cnt[i] = int'(load_value);
                    m_rel[i] = int'(load_value);
                end else if (enable) begin
                    if (m_cnt[i] == 0) begin
                        m_ev     = 1'b1;
                        m_cnt[i] = (i == 1) ? m_rel[i] : TOP;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
                m_wp[i] = m_ev;
                if (m_ev) m_uf[i] = 1'b1;
                else if (clear_flag) m_uf[i] = 1'b0;
            end
            m_e = {W'(m_cnt[i]), m_uf[i], m_wp[i], (m_cnt[i] == 0)};
            if (i == 0) exp_q0.push_back(m_e);
            else exp_q1.push_back(m_e);
        end
    end

    // scoreboard compare process
    logic [EW-1:0] s_e;
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            s_e = exp_q0.pop_front();
            check("ar0_count", 32'(c0), 32'(s_e[EW-1:3]));
            check("ar0_underflow", 32'(uf0), 32'(s_e[2]));
            check("ar0_wrap", 32'(wp0), 32'(s_e[1]));
            check("ar0_zero", 32'(z0), 32'(s_e[0]));
        end
        if (exp_q1.size() > 0) begin
            s_e = exp_q1.pop_front();
            check("ar1_count", 32'(c1), 32'(s_e[EW-1:3]));
            check("ar1_underflow", 32'(uf1), 32'(s_e[2]));
            check("ar1_wrap", 32'(wp1), 32'(s_e[1]));
            check("ar1_zero", 32'(z1), 32'(s_e[0]));
        end
    end

    // driver task: apply one cycle of inputs, return at the following negedge
    task automatic step(input logic rst, input logic ld, input logic [W-1:0] lv,
                        input logic en, input logic clr);
        reset      = rst;
        load       = ld;
        load_value = lv;
        enable     = en;
        clear_flag = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_count", 32'(c0), 15);
        check("rst_flags", 32'({uf0, wp0, z0}), 0);
        check("rst_ar1_count", 32'(c1), 15);

        // free-running countdown through one wrap
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 1, 0);
            if (i == 15) begin
                check("cd_at_zero", 32'(c0), 0);
                check("cd_zero_flag", 32'(z0), 1);
                check("cd_no_uf_yet", 32'(uf0), 0);
            end
        end
        check("cd_wrap_count", 32'(c0), 15);
        check("cd_wrap_flags", 32'({uf0, wp0, z0}), 3'b110);
        step(0, 0, 0, 0, 0);
        check("cd_pulse_drop", 32'({uf0, wp0}), 2'b10);

        // auto-reload from loaded value 3
        step(0, 1, 4'd3, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 1, 0);
            if (i == 3) check("ar_zero", 32'({c1, z1}), {4'd0, 1'b1});
            if (i == 4) check("ar_reload", 32'({c1, wp1}), {4'd3, 1'b1});
        end
        check("ar_after", 32'({c1, wp1, z1}), {4'd2, 2'b00});
        check("fix_after", 32'(c0), 14);

        // load beats enable at count zero
        step(0, 1, 4'd0, 0, 0);
        step(0, 1, 4'd9, 1, 0);
        check("ld_en_count", 32'(c0), 9);
        check("ld_en_flags", 32'({uf0, wp0}), 2'b10);

        // underflow wins over same-edge clear, then a lone clear
        step(0, 1, 4'd0, 0, 0);
        step(0, 0, 0, 1, 1);
        check("clr_set_wins", 32'({uf0, uf1}), 2'b11);
        check("clr_ar1_count", 32'(c1), 0);
        step(0, 0, 0, 0, 1);
        check("clr_alone", 32'({uf0, uf1, wp0}), 0);

        // reset mid-count overrides load/enable and restores reload to all-ones
        step(0, 1, 4'd6, 0, 0);
        step(1, 1, 4'd6, 1, 0);
        check("mid_rst_count", 32'(c1), 15);
        check("mid_rst_flags", 32'({uf1, wp1, z1}), 0);
        for (int i = 1; i <= 16; i++) step(0, 0, 0, 1, 0);
        check("mid_rst_reload", 32'({c1, uf1, wp1}), {4'd15, 2'b11});

        // auto-reload of zero: back-to-back underflows
        step(0, 1, 4'd0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 1, 0);
            check("b2b_ar1", 32'({c1, uf1, wp1, z1}), {4'd0, 3'b111});
        end
        check("b2b_ar0", 32'({c0, wp0}), {4'd13, 1'b0});

        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_underflow.md
# countdown_underflow

Parameterised loadable down-counter with sticky underflow flag and a single-cycle wrap pulse, the counting-down counterpart of the team's 4-bit up-counter with overflow. It sits next to the up-counter in timer and event-budget paths. Software or a controller loads a start value and the block decrements on each enabled cycle. Underflow is reported both as a level (sticky until cleared) and as an edge (one-cycle pulse).

## Interface
- WIDTH, 4, counter width in bits (≥2)
- AUTO_RELOAD, 0, 0: wrap from 0 to all-ones; 1: wrap from 0 to the last loaded value
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- load  input  1  when high, counter takes load_value this cycle; also captures reload register
- load_value  input  WIDTH  value to load
- enable  input  1  decrement when high (and load low)
- clear_flag  input  1  clears sticky underflow_out
- counter_out  output  WIDTH  current count (registered)
- underflow_out  output  1  sticky underflow flag (registered)
- wrap_pulse  output  1  high for exactly one cycle after each underflow event (registered)
- zero_out  output  1  registered, high when counter_out == 0

## Operation
- Priority per edge: reset > load > enable > hold.
- reset: counter_out = all-ones (2^WIDTH-1), reload register = all-ones, underflow_out = 0, wrap_pulse = 0, zero_out = 0.
- load: counter_out <= load_value; reload register <= load_value; no underflow event even if enable is high and count is 0; zero_out <= (load_value == 0).
- enable, count > 0: counter_out <= counter_out - 1; zero_out <= (counter_out == 1).
- enable, count == 0 (underflow event): counter_out <= all-ones (AUTO_RELOAD=0) or reload register (AUTO_RELOAD=1); underflow_out <= 1; wrap_pulse <= 1; zero_out updated to match the new count.
- Neither load nor enable: all registers hold; wrap_pulse <= 0.
- wrap_pulse deasserts on every edge that is not an underflow event. Back-to-back underflows keep it high, e.g. AUTO_RELOAD=1 with reload value 0.
- clear_flag: underflow_out <= 0, unless an underflow event occurs on the same edge, in which case set wins (underflow_out = 1).
- clear_flag has no effect on counter_out, wrap_pulse or zero_out.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- All outputs are registered; a change at the inputs is visible on outputs after the next rising clk edge (latency 1).
- No combinational path from any input to any output.
- Reset mid-count takes effect on the next edge regardless of load/enable/clear_flag.
- underflow_out rises on the same edge where counter_out wraps.
- wrap_pulse is high in the cycle immediately following that edge.

## Test plan
- Reset, then enable held for 16 cycles (WIDTH=4, AUTO_RELOAD=0) -> counter_out 15,14,...,0 then 15. underflow_out and wrap_pulse rise on the 0→15 edge. wrap_pulse low the next cycle, underflow_out stays 1.
- load=1, load_value=3, then enable for 5 cycles (AUTO_RELOAD=1) -> 3,2,1,0,3,2. zero_out high only while count=0. One wrap_pulse.
- Count=0, enable=1, load=1, load_value=9 on same edge -> counter_out=9, no wrap_pulse, underflow_out unchanged.
- underflow_out=1, count=0, enable=1 and clear_flag=1 on same edge -> underflow_out stays 1. clear_flag alone on next edge -> 0.
- Mid-count (count=6, enable=1, load=1) reset asserted -> next edge counter_out=15, all flags 0, reload register=15 (verify by AUTO_RELOAD=1 wrap reloading 15).
- AUTO_RELOAD=1, load_value=0, enable held 3 cycles -> counter_out stays 0, wrap_pulse high every cycle after the first enabled edge, underflow_out=1.
